// File: rtl/seradd_frame_driver_pkg.sv
// Shared types and constants for the serial-adder frame driver.
package seradd_pkg;

  localparam int FRAME_W = 4;

  typedef logic [1:0] phase_t;

  typedef struct packed {
    logic [FRAME_W-1:0] sum;
    logic               ovf;
    logic               live;
  } result_t;

  localparam phase_t LOAD_PH = 2'd3;
  localparam phase_t OVF_PH  = 2'd1;

  function automatic logic [FRAME_W:0] frame_sum(input logic [FRAME_W-1:0] a,
                                                 input logic [FRAME_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/seradd_frame_driver_if.sv
// Operand handshake, serial adder lines and result beat of the frame driver.
interface seradd_frame_driver_if;
  import seradd_pkg::*;

  logic               op_valid;
  logic               op_ready;
  logic [FRAME_W-1:0] op_a;
  logic [FRAME_W-1:0] op_b;
  logic               LINE1;
  logic               LINE2;
  logic               OUTP;
  logic               OVERFLW;
  logic               res_valid;
  logic [FRAME_W-1:0] res_sum;
  logic               res_ovf;
  logic               res_err;

  modport master (
    output op_valid, op_a, op_b, OUTP, OVERFLW,
    input  op_ready, LINE1, LINE2, res_valid, res_sum, res_ovf, res_err
  );

  modport slave (
    input  op_valid, op_a, op_b, OUTP, OVERFLW,
    output op_ready, LINE1, LINE2, res_valid, res_sum, res_ovf, res_err
  );

endinterface

// File: rtl/seradd_frame_driver_capture.sv
// seradd_capture: collects the adder's registered sum bits by phase and
// publishes a completed frame (sum + overflow) once the overflow flag lands.
module seradd_capture
  import seradd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  phase_t             ph,
  input  logic               outp,
  input  logic               overflw,
  input  logic               live,
  output logic               res_valid,
  output logic [FRAME_W-1:0] res_sum,
  output logic               res_ovf
);

  logic [FRAME_W-1:0] cap_en;
  logic [FRAME_W-1:0] sum_reg;
  logic               valid_reg;
  logic [FRAME_W-1:0] res_sum_reg;
  logic               res_ovf_reg;
  result_t            frame_c;

  // The adder's sum register lags the lines by one cycle, so bit k arrives at ph k+1.
  genvar gi;
  generate
    for (gi = 0; gi < FRAME_W; gi++) begin : g_cap
      assign cap_en[gi] = (ph == phase_t'((gi + 1) % FRAME_W));
    end
  endgenerate

  assign frame_c = '{sum: sum_reg, ovf: overflw, live: live};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg     <= '0;
      valid_reg   <= 1'b0;
      res_sum_reg <= '0;
      res_ovf_reg <= 1'b0;
    end else begin
      for (int i = 0; i < FRAME_W; i++) begin
        if (cap_en[i]) sum_reg[i] <= outp;
      end
      valid_reg <= 1'b0;
      if (ph == OVF_PH) begin
        valid_reg <= frame_c.live;
        if (frame_c.live) begin
          res_sum_reg <= frame_c.sum;
          res_ovf_reg <= frame_c.ovf;
        end
      end
    end
  end

  assign res_valid = valid_reg;
  assign res_sum   = res_sum_reg;
  assign res_ovf   = res_ovf_reg;

endmodule

// File: rtl/seradd_frame_driver.sv
// Word-to-serial frame driver for the 4-bit serial adder; optional result
// self-check enabled with the SERADD_CHECK_EN macro.
module seradd_frame_driver
  import seradd_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  seradd_frame_driver_if.slave bus
);

  phase_t             ph_reg;
  logic               hold_full_reg;
  logic [FRAME_W-1:0] hold_a_reg;
  logic [FRAME_W-1:0] hold_b_reg;
  logic [FRAME_W-1:0] shift_a_reg;
  logic [FRAME_W-1:0] shift_b_reg;
  logic               line1_reg;
  logic               line2_reg;
  logic               live_cur_reg;
  logic               live_prev_reg;

  logic               load_edge;
  logic               accept;
  logic               bypass;
  logic               load_hold;
  logic [FRAME_W-1:0] load_a;
  logic [FRAME_W-1:0] load_b;
  logic               load_live;

  logic               cap_valid;
  logic [FRAME_W-1:0] cap_sum;
  logic               cap_ovf;

  assign load_edge   = (ph_reg == LOAD_PH);
  assign accept      = bus.op_valid && !hold_full_reg;
  assign bypass      = load_edge && accept;
  assign load_hold   = load_edge && hold_full_reg;
  assign bus.op_ready = !hold_full_reg;

  always_comb begin
    load_a    = '0;
    load_b    = '0;
    load_live = 1'b0;
    if (load_hold) begin
      load_a    = hold_a_reg;
      load_b    = hold_b_reg;
      load_live = 1'b1;
    end else if (bypass) begin
      load_a    = bus.op_a;
      load_b    = bus.op_b;
      load_live = 1'b1;
    end
  end

  // Draining and refilling on the same edge leaves the new operand in hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_reg <= 1'b0;
      hold_a_reg    <= '0;
      hold_b_reg    <= '0;
    end else begin
      if (load_hold) hold_full_reg <= 1'b0;
      if (accept && !bypass) begin
        hold_full_reg <= 1'b1;
        hold_a_reg    <= bus.op_a;
        hold_b_reg    <= bus.op_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_reg        <= '0;
      shift_a_reg   <= '0;
      shift_b_reg   <= '0;
      line1_reg     <= 1'b0;
      line2_reg     <= 1'b0;
      live_cur_reg  <= 1'b0;
      live_prev_reg <= 1'b0;
    end else begin
      ph_reg <= ph_reg + 2'd1;
      if (load_edge) begin
        line1_reg     <= load_a[0];
        line2_reg     <= load_b[0];
        shift_a_reg   <= load_a >> 1;
        shift_b_reg   <= load_b >> 1;
        live_cur_reg  <= load_live;
        live_prev_reg <= live_cur_reg;
      end else begin
        line1_reg   <= shift_a_reg[0];
        line2_reg   <= shift_b_reg[0];
        shift_a_reg <= shift_a_reg >> 1;
        shift_b_reg <= shift_b_reg >> 1;
      end
    end
  end

  assign bus.LINE1 = line1_reg;
  assign bus.LINE2 = line2_reg;

  seradd_capture u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .ph        (ph_reg),
    .outp      (bus.OUTP),
    .overflw   (bus.OVERFLW),
    .live      (live_prev_reg),
    .res_valid (cap_valid),
    .res_sum   (cap_sum),
    .res_ovf   (cap_ovf)
  );

  assign bus.res_valid = cap_valid;
  assign bus.res_sum   = cap_sum;
  assign bus.res_ovf   = cap_ovf;

`ifdef SERADD_CHECK_EN
  logic [FRAME_W:0] exp_cur_reg;
  logic [FRAME_W:0] exp_prev_reg;
  logic             err_reg;

  // exp_prev stays stable until the next load edge, past the result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cur_reg  <= '0;
      exp_prev_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (load_edge) begin
        exp_cur_reg  <= frame_sum(load_a, load_b);
        exp_prev_reg <= exp_cur_reg;
      end
      if (cap_valid && ({cap_ovf, cap_sum} != exp_prev_reg)) err_reg <= 1'b1;
    end
  end

  assign bus.res_err = err_reg;
`else
  assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_seradd_frame_driver.sv
// Bench for seradd_frame_driver with a behavioural serial adder attached.
module tb_seradd_frame_driver;
  import seradd_pkg::*;

`ifdef SERADD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seradd_frame_driver_if bus();

  seradd_frame_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Serial adder model: 4-cycle frames aligned to reset release, registered sum,
  // carry-out of a frame shown on OVERFLW alongside the next frame's bit-0 sum.
  logic [1:0] tb_ph;
  logic       add_sum, add_c, add_ovf, inv;
  logic [1:0] add_t;
  int         cyc = 0;

  assign add_t = {1'b0, bus.LINE1} + {1'b0, bus.LINE2} + {1'b0, (tb_ph == 2'd0) ? 1'b0 : add_c};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_ph   <= 2'd0;
      add_sum <= 1'b0;
      add_c   <= 1'b0;
      add_ovf <= 1'b0;
    end else begin
      tb_ph   <= tb_ph + 2'd1;
      add_sum <= add_t[0];
      add_c   <= add_t[1];
      add_ovf <= (tb_ph == 2'd0) ? add_c : 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.OUTP    = add_sum ^ inv;
  assign bus.OVERFLW = add_ovf;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: timeout waiting for DUT, got none, expected event", name);
  endtask

  // Scoreboard for the randomized phase: expected result is simply a + b.
  logic [4:0] sb_q[$];
  logic [4:0] sb_exp;
  bit         sb_en = 1'b0;
  int         acc_cyc;

  always @(negedge clk) begin
    if (sb_en && rst_n && bus.res_valid) begin
      if (sb_q.size() == 0) begin
        timeout_fail("rand_spurious_result");
      end else begin
        sb_exp = sb_q.pop_front();
        check("rand_result", {bus.res_ovf, bus.res_sum}, sb_exp);
        $display("rand result sum=%b ovf=%b", bus.res_sum, bus.res_ovf);
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_ready) begin
      timeout_fail("send_op_ready");
      bus.op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (sb_en) sb_q.push_back({1'b0, a} + {1'b0, b});
    @(negedge clk);
    acc_cyc = cyc;
    $display("accept a=%0d b=%0d at cycle %0d", a, b, acc_cyc);
  endtask

  task automatic wait_res(output logic [3:0] s, output logic o, output int c);
    int n = 0;
    s = '0;
    o = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 40);
    if (!bus.res_valid) begin
      timeout_fail("wait_res_valid");
    end else begin
      s = bus.res_sum;
      o = bus.res_ovf;
      c = cyc;
      $display("result sum=%b ovf=%b at cycle %0d", s, o, c);
    end
  endtask

  task automatic wait_ph(input logic [1:0] p);
    while (tb_ph != p) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_line1"}, bus.LINE1, 1'b0);
    check({tag, "_line2"}, bus.LINE2, 1'b0);
    check({tag, "_op_ready"}, bus.op_ready, 1'b1);
    check({tag, "_res_valid"}, bus.res_valid, 1'b0);
    check({tag, "_res_sum"}, bus.res_sum, 4'd0);
    check({tag, "_res_ovf"}, bus.res_ovf, 1'b0);
    check({tag, "_res_err"}, bus.res_err, 1'b0);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       ovf;
  } vec_t;

  vec_t       tbl[8];
  logic [3:0] rs[3];
  logic       ro[3];
  int         rc[3];
  logic [3:0] s;
  logic       o;
  int         c;
  int         cnt;
  logic [3:0] va, vb;

  initial begin
    tbl[0] = '{4'd15, 4'd1,  4'b0000, 1'b1};
    tbl[1] = '{4'd5,  4'd5,  4'b1010, 1'b0};
    tbl[2] = '{4'd0,  4'd0,  4'b0000, 1'b0};
    tbl[3] = '{4'd2,  4'd2,  4'b0100, 1'b0};
    tbl[4] = '{4'd7,  4'd9,  4'b0000, 1'b1};
    tbl[5] = '{4'd8,  4'd7,  4'b1111, 1'b0};
    tbl[6] = '{4'd15, 4'd15, 4'b1110, 1'b1};
    tbl[7] = '{4'd12, 4'd6,  4'b0010, 1'b1};

    inv = 1'b0;
    rst_n = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // 3+4 offered right at reset release: line streams, op_ready and latency
    va = 4'd3;
    vb = 4'd4;
    send(va, vb);
    bus.op_valid = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e > 1) @(negedge clk);
      check("first_op_ready", bus.op_ready, e >= 4);
      if (e >= 4 && e <= 7) begin
        check("first_line1", bus.LINE1, va[e-4]);
        check("first_line2", bus.LINE2, vb[e-4]);
      end
      check("first_res_valid", bus.res_valid, e == 10);
      if (e == 10) begin
        check("first_res_sum", bus.res_sum, 4'b0111);
        check("first_res_ovf", bus.res_ovf, 1'b0);
      end
    end

    // 9+8 overflows; the following idle frame yields no result
    send(4'd9, 4'd8);
    bus.op_valid = 1'b0;
    wait_res(s, o, c);
    check("ovf_res_sum", s, 4'b0001);
    check("ovf_res_ovf", o, 1'b1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.res_valid) cnt++;
    end
    check("ovf_idle_no_result", cnt, 0);
    check("ovf_flag_cleared", bus.OVERFLW, 1'b0);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b);
      bus.op_valid = 1'b0;
      wait_res(s, o, c);
      check("table_sum", s, tbl[i].sum);
      check("table_ovf", o, tbl[i].ovf);
    end

    // back-to-back with op_valid held
    fork
      begin
        send(4'd15, 4'd1);
        send(4'd5, 4'd5);
        check("b2b_ready_low", bus.op_ready, 1'b0);
        send(4'd0, 4'd0);
        bus.op_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) wait_res(rs[k], ro[k], rc[k]);
      end
    join
    check("b2b_sum0", rs[0], 4'b0000);
    check("b2b_ovf0", ro[0], 1'b1);
    check("b2b_sum1", rs[1], 4'b1010);
    check("b2b_ovf1", ro[1], 1'b0);
    check("b2b_sum2", rs[2], 4'b0000);
    check("b2b_ovf2", ro[2], 1'b0);
    check("b2b_gap01", rc[1] - rc[0], 4);
    check("b2b_gap12", rc[2] - rc[1], 4);

    // bypass: operand first offered in the ph==3 cycle with hold empty
    wait_ph(2'd3);
    check("bypass_ready_before", bus.op_ready, 1'b1);
    send(4'd6, 4'd3);
    bus.op_valid = 1'b0;
    check("bypass_hold_empty", bus.op_ready, 1'b1);
    wait_res(s, o, c);
    check("bypass_sum", s, 4'b1001);
    check("bypass_ovf", o, 1'b0);
    check("bypass_latency", c - acc_cyc, 6);

    // hold full at the ph==3 edge: order preserved
    wait_ph(2'd0);
    send(4'd1, 4'd2);
    bus.op_valid = 1'b0;
    wait_ph(2'd3);
    check("holdfull_ready_low", bus.op_ready, 1'b0);
    send(4'd4, 4'd4);
    bus.op_valid = 1'b0;
    wait_res(s, o, c);
    check("holdfull_first_sum", s, 4'b0011);
    check("holdfull_first_ovf", o, 1'b0);
    wait_res(s, o, c);
    check("holdfull_second_sum", s, 4'b1000);
    check("holdfull_second_ovf", o, 1'b0);

    // reset pulsed at ph==2 of a live frame
    wait_ph(2'd0);
    send(4'd6, 4'd7);
    bus.op_valid = 1'b0;
    wait_ph(2'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.res_valid) cnt++;
    end
    check("midreset_no_result", cnt, 0);
    send(4'd2, 4'd2);
    bus.op_valid = 1'b0;
    wait_res(s, o, c);
    check("midreset_next_sum", s, 4'b0100);
    check("midreset_next_ovf", o, 1'b0);

    // OUTP inverted for exactly one frame's four sum bits
    wait_ph(2'd0);
    send(4'd3, 4'd5);
    bus.op_valid = 1'b0;
    wait_ph(2'd3);
    repeat (2) @(negedge clk);
    inv = 1'b1;
    repeat (4) @(negedge clk);
    inv = 1'b0;
    @(negedge clk);
    check("inv_res_valid", bus.res_valid, 1'b1);
    check("inv_res_sum", bus.res_sum, 4'b0111);
    check("inv_res_ovf", bus.res_ovf, 1'b0);
    @(negedge clk);
    check("inv_res_err", bus.res_err, CHK);
    send(4'd1, 4'd1);
    bus.op_valid = 1'b0;
    wait_res(s, o, c);
    check("inv_after_sum", s, 4'b0010);
    repeat (2) @(negedge clk);
    check("inv_err_sticky", bus.res_err, CHK);

    // randomized traffic against the scoreboard
    sb_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cnt = $urandom_range(0, 5);
      if (cnt > 0) begin
        bus.op_valid = 1'b0;
        repeat (cnt) @(negedge clk);
      end
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    bus.op_valid = 1'b0;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 80) begin
      @(negedge clk);
      cnt++;
    end
    if (sb_q.size() != 0) timeout_fail("rand_drain");
    repeat (8) @(negedge clk);
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

endmodule
